data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Single-port data memory responder: word RAM, an LED register and a free-running cycle
// counter behind a valid/ready request port with a fixed number of wait states.
module data_mem_responder #(
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] led_out
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [3:0]  WaitLoad = 4'(WAIT_CYC);
  localparam logic [31:0] LedAddr  = 32'hFFFF_0000;
  localparam logic [31:0] CntAddr  = 32'hFFFF_0004;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q;
  logic [3:0]  wait_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [15:0] led_q;
  logic [31:0] cycle_q;

  logic [31:0] mem [DEPTH];

  logic          ram_hit, led_hit, cnt_hit, acc_err;
  logic          resp_live, commit;
  logic [AW-1:0] word_idx;
  logic [15:0]   led_wr;
  logic [31:0]   rd_data;

  // Decode works on the latched request so the requester may drop its inputs after acceptance.
  always_comb begin
    ram_hit  = (addr_q >> (AW + 2)) == 32'd0;
    led_hit  = addr_q == LedAddr;
    cnt_hit  = addr_q == CntAddr;
    acc_err  = (addr_q[1:0] != 2'b00) || !(ram_hit || led_hit || cnt_hit) || (cnt_hit && we_q);
    word_idx = addr_q[AW+1:2];
    led_wr   = {be_q[1] ? wdata_q[15:8] : led_q[15:8], be_q[0] ? wdata_q[7:0] : led_q[7:0]};
  end

  always_comb begin
    rd_data = 32'd0;
    if (!acc_err && !we_q) begin
      if (ram_hit) begin
        rd_data = mem[word_idx];
      end else if (led_hit) begin
        rd_data = {16'h0000, led_q};
      end else if (cnt_hit) begin
        rd_data = cycle_q;
      end
    end
  end

  // A reset landing on the RESP cycle suppresses both the strobe and the commit.
  assign resp_live = (state_q == StResp) && !rst;
  assign commit    = resp_live && we_q && !acc_err;

  assign req_ready = (state_q == StIdle) && !rst;
  assign rsp_valid = resp_live;
  assign rsp_err   = resp_live && acc_err;
  assign rsp_rdata = resp_live ? rd_data : 32'd0;
  // The LED write is visible during RESP itself and becomes permanent at the end of it.
  assign led_out   = (commit && led_hit) ? led_wr : led_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      wait_q  <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      led_q   <= 16'd0;
      cycle_q <= 32'd0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            if (WAIT_CYC == 0) begin
              state_q <= StResp;
            end else begin
              state_q <= StWait;
              wait_q  <= WaitLoad;
            end
          end
        end
        StWait: begin
          wait_q <= wait_q - 4'd1;
          if (wait_q == 4'd1) begin
            state_q <= StResp;
          end
        end
        StResp: begin
          state_q <= StIdle;
          if (commit && led_hit) begin
            led_q <= led_wr;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (commit && ram_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          mem[word_idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

endmodule
